// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl_pkg
// Brief    : Shared encodings for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_hazard_ctrl_pkg;

    // ALU operand source select
    localparam logic [1:0] c_FWD_RD  = 2'b00;
    localparam logic [1:0] c_FWD_WB  = 2'b01;
    localparam logic [1:0] c_FWD_MEM = 2'b10;

    // Memory-wait FSM state codes
    localparam logic [0:0] c_ST_RUN      = 1'b0;
    localparam logic [0:0] c_ST_MEM_WAIT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl_fwd_select
// Brief    : Bypass select for one Execute-stage operand (Memory beats WB).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl_fwd_select
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [REG_ADDR_W-1:0] i_rd_m,
    input  logic                  i_we_m,
    input  logic [REG_ADDR_W-1:0] i_rd_wb,
    input  logic                  i_we_wb,
    output logic [1:0]            o_fwd
);

    logic w_rs_nz;
    logic w_hit_m;
    logic w_hit_wb;

    // x0 is hard-wired, so it never takes a bypass
    assign w_rs_nz  = (i_rs != '0);
    assign w_hit_m  = w_rs_nz & i_we_m  & (i_rd_m  == i_rs);
    assign w_hit_wb = w_rs_nz & i_we_wb & (i_rd_wb == i_rs);

    always_comb begin
        o_fwd = c_FWD_RD;
        if (w_hit_m) begin
            o_fwd = c_FWD_MEM;
        end else if (w_hit_wb) begin
            o_fwd = c_FWD_WB;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Brief    : Stall/flush/forward control for the 5-stage F-D-E-M-WB pipeline.
//            Define FORWARDING_EN to enable operand bypass; otherwise RAW
//            hazards against E/M writers stall Fetch/Decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_D,
    input  logic [REG_ADDR_W-1:0] rs2_D,
    input  logic [REG_ADDR_W-1:0] rs1_E,
    input  logic [REG_ADDR_W-1:0] rs2_E,
    input  logic [REG_ADDR_W-1:0] rd_E,
    input  logic [REG_ADDR_W-1:0] rd_M,
    input  logic [REG_ADDR_W-1:0] rd_WB,
    input  logic                  RF_WE_E,
    input  logic                  RF_WE_M,
    input  logic                  RF_WE_WB,
    input  logic                  Load_E,
    input  logic                  branch_taken_E,
    input  logic                  dm_req_M,
    input  logic                  dm_ready_M,
    output logic                  stall_F,
    output logic                  stall_D,
    output logic                  stall_E,
    output logic                  stall_M,
    output logic                  flush_D,
    output logic                  flush_E,
    output logic                  flush_WB,
    output logic [1:0]            fwd_a_E,
    output logic [1:0]            fwd_b_E,
    output logic                  mem_timeout_err,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int c_WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

    logic [0:0]          r_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_err;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic       w_mem_wait;
    logic       w_hit_e;
    logic       w_hit_m;
    logic       w_d_hazard;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    assign w_mem_wait = ((r_state == c_ST_MEM_WAIT) |
                         ((r_state == c_ST_RUN) & dm_req_M & ~dm_ready_M)) & ~dm_ready_M;

    assign w_hit_e = (rd_E != '0) & ((rd_E == rs1_D) | (rd_E == rs2_D));
    assign w_hit_m = (rd_M != '0) & ((rd_M == rs1_D) | (rd_M == rs2_D));

`ifdef FORWARDING_EN
    assign w_d_hazard = Load_E & RF_WE_E & w_hit_e;

    pipeline_hazard_ctrl_fwd_select #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_a (
        .i_rs    (rs1_E),
        .i_rd_m  (rd_M),
        .i_we_m  (RF_WE_M),
        .i_rd_wb (rd_WB),
        .i_we_wb (RF_WE_WB),
        .o_fwd   (w_fwd_a)
    );

    pipeline_hazard_ctrl_fwd_select #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_b (
        .i_rs    (rs2_E),
        .i_rd_m  (rd_M),
        .i_we_m  (RF_WE_M),
        .i_rd_wb (rd_WB),
        .i_we_wb (RF_WE_WB),
        .o_fwd   (w_fwd_b)
    );
`else
    logic w_unused_fwd;

    // Without bypass, any pending E/M write to a Decode source must drain first
    assign w_d_hazard   = (RF_WE_E & w_hit_e) | (RF_WE_M & w_hit_m);
    assign w_fwd_a      = c_FWD_RD;
    assign w_fwd_b      = c_FWD_RD;
    assign w_unused_fwd = ^{rs1_E, rs2_E, rd_WB, RF_WE_WB, Load_E};
`endif

    always_comb begin
        stall_F  = 1'b0;
        stall_D  = 1'b0;
        stall_E  = 1'b0;
        stall_M  = 1'b0;
        flush_D  = 1'b0;
        flush_E  = 1'b0;
        flush_WB = 1'b0;
        fwd_a_E  = c_FWD_RD;
        fwd_b_E  = c_FWD_RD;
        if (rst) begin
            flush_D  = 1'b1;
            flush_E  = 1'b1;
            flush_WB = 1'b1;
        end else begin
            fwd_a_E = w_fwd_a;
            fwd_b_E = w_fwd_b;
            // Memory wait freezes everything up to M; branch/load-use wait their turn
            if (w_mem_wait) begin
                stall_F  = 1'b1;
                stall_D  = 1'b1;
                stall_E  = 1'b1;
                stall_M  = 1'b1;
                flush_WB = 1'b1;
            end else if (branch_taken_E) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
            end else if (w_d_hazard) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_RUN;
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (dm_req_M & ~dm_ready_M) begin
                        r_state    <= c_ST_MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                default: begin
                    if (dm_ready_M) begin
                        r_state <= c_ST_RUN;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                    end
                end
            endcase
            if (stall_F && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign mem_timeout_err = r_err;
    assign stall_cnt       = r_stall_cnt;

endmodule

`default_nettype wire
